// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One product/quotient bit per clock; signed operations work on magnitudes and fix the sign at the end.
module mdu_hilo #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_wr,
    input  logic            lo_wr,
    input  logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              div_q, div_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   raw_a_q, raw_a_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              is_signed;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        raw_a_d   = raw_a_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_signed = ~op[0];
        trial     = '0;
        diff      = '0;
        sum       = '0;
        prod      = '0;

        case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    div_d   = op[1];
                    opa_d   = (is_signed && a[XLEN-1]) ? -a : a;
                    opb_d   = (is_signed && b[XLEN-1]) ? -b : b;
                    raw_a_d = a;
                    qneg_d  = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_d  = is_signed & a[XLEN-1];
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                if (div_q) begin
                    // Restoring divide: remainder lives in acc high half, quotient shifts into low half.
                    trial = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
                    diff  = trial[XLEN-1:0] - opb_q;
                    if (trial >= {1'b0, opb_q}) begin
                        acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                    opa_d = opa_q << 1;
                end else begin
                    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
                    acc_d = {sum, acc_q[XLEN-1:1]};
                    opb_d = opb_q >> 1;
                end
                if (count_q == CW'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    if (opb_q == '0) begin
                        hi_d = raw_a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                        hi_d = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                    end
                end else begin
                    prod = qneg_q ? -acc_q : acc_q;
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            raw_a_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            raw_a_q <= raw_a_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_wr, lo_wr;
    logic [31:0] wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectorCount = 0;
    int failCount   = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mdu_hilo #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference result from plain 64-bit arithmetic: {HI, LO}.
    function automatic logic [63:0] refResult(logic [1:0] fop, logic [31:0] fa, logic [31:0] fb);
        longint      sa, sb;
        logic [63:0] ua, ub, q, r;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        ua = {32'b0, fa};
        ub = {32'b0, fb};
        case (fop)
            MULT:  return sa * sb;
            MULTU: return ua * ub;
            DIV: begin
                if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (fb == 32'd0) return {fa, 32'hFFFF_FFFF};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    logic [31:0] mHi = '0, mLo = '0;
    logic        mDone = 1'b0;
    logic [63:0] mRes = '0;
    int          mRemain = 0;

    // Model: an accepted op commits its precomputed result 33 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHi <= '0; mLo <= '0; mDone <= 1'b0; mRemain <= 0;
        end else begin
            mDone <= 1'b0;
            if (mRemain == 0) begin
                if (hi_wr) mHi <= wr_data;
                if (lo_wr) mLo <= wr_data;
                if (start) begin
                    mRes    <= refResult(op, a, b);
                    mRemain <= 33;
                end
            end else begin
                mRemain <= mRemain - 1;
                if (mRemain == 1) begin
                    mHi   <= mRes[63:32];
                    mLo   <= mRes[31:0];
                    mDone <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("model_hi",   {32'b0, hi},  {32'b0, mHi});
            checkOutput("model_lo",   {32'b0, lo},  {32'b0, mLo});
            checkOutput("model_busy", {63'b0, busy}, {63'b0, (mRemain != 0)});
            checkOutput("model_done", {63'b0, done}, {63'b0, mDone});
        end
    end

    task automatic applyStimulus(logic s, logic [1:0] o, logic [31:0] va, logic [31:0] vb,
                                 logic hw, logic lw, logic [31:0] wd);
        start = s; op = o; a = va; b = vb; hi_wr = hw; lo_wr = lw; wr_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(logic [1:0] o, logic [31:0] va, logic [31:0] vb);
        applyStimulus(1'b1, o, va, vb, 1'b0, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic waitDone(output int ticks, output int busyCycles);
        ticks = 0;
        busyCycles = 0;
        while (done !== 1'b1 && ticks < 40) begin
            if (busy === 1'b1) busyCycles++;
            tick();
            ticks++;
        end
        checkOutput("done_seen", {63'b0, done}, 64'd1);
    endtask

    task automatic runOp(string name, logic [1:0] o, logic [31:0] va, logic [31:0] vb,
                         logic [31:0] expHi, logic [31:0] expLo);
        int t, bc;
        launch(o, va, vb);
        waitDone(t, bc);
        checkOutput({name, "_hi"}, {32'b0, hi}, {32'b0, expHi});
        checkOutput({name, "_lo"}, {32'b0, lo}, {32'b0, expLo});
        checkOutput({name, "_latency"}, 64'(t), 64'd33);
    endtask

    initial begin
        int t, bc;
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkOutput("reset_hi",   {32'b0, hi}, 64'd0);
        checkOutput("reset_lo",   {32'b0, lo}, 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        tick();

        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(t, bc);
        checkOutput("multu_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        checkOutput("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
        checkOutput("multu_max_busy_cycles", 64'(bc), 64'd33);
        checkOutput("multu_max_latency", 64'(t), 64'd33);
        tick();
        checkOutput("done_one_cycle", {63'b0, done}, 64'd0);

        runOp("mult_neg",  MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();
        runOp("div_neg",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        runOp("divu_zero", DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        tick();
        runOp("div_ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        tick();
        runOp("div_zero_signed", DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        tick();
        runOp("mult_both_neg", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        tick();
        runOp("div_rem_neg", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003);
        tick();

        // Start and MTHI arriving mid-operation must both be dropped.
        launch(DIVU, 32'd10, 32'd3);
        repeat (9) tick();
        applyStimulus(1'b1, MULTU, 32'd5, 32'd5, 1'b1, 1'b0, 32'h1234);
        tick();
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        waitDone(t, bc);
        checkOutput("ignored_hi", {32'b0, hi}, 64'd1);
        checkOutput("ignored_lo", {32'b0, lo}, 64'd3);
        repeat (3) begin
            tick();
            checkOutput("ignored_single_done", {63'b0, done}, 64'd0);
        end

        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("mthi_hi", {32'b0, hi}, 64'hCAFE_F00D);
        checkOutput("mtlo_lo", {32'b0, lo}, 64'hCAFE_F00D);

        // Asynchronous reset mid-operation aborts with no done pulse.
        launch(MULTU, 32'd2, 32'd3);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {63'b0, busy}, 64'd0);
        checkOutput("abort_hi",   {32'b0, hi}, 64'd0);
        checkOutput("abort_lo",   {32'b0, lo}, 64'd0);
        checkOutput("abort_done", {63'b0, done}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (25) begin
            tick();
            checkOutput("abort_no_done", {63'b0, done}, 64'd0);
        end

        // Back-to-back: second start issued in the done cycle of the first.
        launch(MULTU, 32'd6, 32'd7);
        waitDone(t, bc);
        checkOutput("b2b_first_lo", {32'b0, lo}, 64'd42);
        checkOutput("b2b_first_hi", {32'b0, hi}, 64'd0);
        launch(DIVU, 32'd9, 32'd4);
        checkOutput("b2b_second_busy", {63'b0, busy}, 64'd1);
        waitDone(t, bc);
        checkOutput("b2b_second_lo", {32'b0, lo}, 64'd2);
        checkOutput("b2b_second_hi", {32'b0, hi}, 64'd1);
        checkOutput("b2b_second_latency", 64'(t), 64'd33);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
